cenc_punc_enc: RTL and testbench

//  Parametrised K=7 convolutional encoder with runtime-selectable puncturing (1/2, 2/3, 3/4).

---
 rtl/cenc_punc_enc.sv | 204 ++++++++++++++++++++
 tb/tb_cenc_punc_enc.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cenc_punc_enc.sv
// K=7 convolutional encoder with runtime-selectable puncturing (1/2, 2/3, 3/4) and OFDM symbol tagging.
// Optional zero-tail insertion is built when CENC_TAIL_EN is defined.
`timescale 1ns/1ps

module cenc_punc_enc #(
  parameter logic [6:0] G0         = 7'o133,
  parameter logic [6:0] G1         = 7'o171,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CBPS_W     = 9
) (
  input  logic              sce_clk_i,
  input  logic              sce_rst,
  input  logic              start,
  input  logic [1:0]        rate,
  input  logic [5:0]        init_state,
  input  logic [CBPS_W-1:0] n_cbps,
  input  logic              di,
  input  logic              di_vld,
  output logic              di_rdy,
  input  logic              tail_req,
  output logic              tail_busy,
  output logic              do_bit,
  output logic              do_vld,
  input  logic              do_rdy,
  output logic              do_sym_last,
  output logic [3:0]        do_sym_num
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] RATE_12 = 2'd0;
  localparam logic [1:0] RATE_23 = 2'd1;
  localparam logic [1:0] RATE_34 = 2'd2;
  localparam logic [CBPS_W-1:0] CBPS_ONE = CBPS_W'(1);

  logic [5:0]        sr;
  logic [1:0]        rate_q;
  logic [1:0]        phase;
  logic [1:0]        phase_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              mem [FIFO_DEPTH];
  logic              rdy_en;
  logic [CBPS_W-1:0] bit_cnt;
  logic [3:0]        sym_num;

  logic              free_ok;
  logic              accept;
  logic              tail_step;
  logic              enc_step;
  logic              enc_in;
  logic              code_a;
  logic              code_b;
  logic [1:0]        push_n;
  logic              b0;
  logic              b1;
  logic              pop;
  int                wr_i;

  function automatic logic parity7(input logic [6:0] g, input logic [6:0] v);
    return ^(g & v);
  endfunction

  assign free_ok = (cnt <= CNT_W'(FIFO_DEPTH - 2));
  assign di_rdy  = rdy_en & free_ok & ~start & ~tail_busy;
  assign accept  = di_vld & di_rdy;
  assign enc_step = accept | tail_step;

`ifdef CENC_TAIL_EN
  logic       tail_q;
  logic [2:0] tail_cnt;

  assign tail_busy = tail_q;
  assign tail_step = tail_q & free_ok & ~start;
  // While the tail runs di_rdy is low, so the encoder input is forced to zero.
  assign enc_in    = tail_q ? 1'b0 : di;

  always_ff @(posedge sce_clk_i or posedge sce_rst) begin
    if (sce_rst) begin
      tail_q   <= 1'b0;
      tail_cnt <= 3'd0;
    end else if (start) begin
      tail_q   <= 1'b0;
      tail_cnt <= 3'd0;
    end else if (!tail_q) begin
      if (tail_req) begin
        tail_q   <= 1'b1;
        tail_cnt <= 3'd0;
      end
    end else if (tail_step) begin
      if (tail_cnt == 3'd5) begin
        tail_q   <= 1'b0;
        tail_cnt <= 3'd0;
      end else begin
        tail_cnt <= tail_cnt + 3'd1;
      end
    end
  end
`else
  logic tail_req_unused;

  assign tail_req_unused = tail_req;
  assign tail_busy       = 1'b0;
  assign tail_step       = 1'b0;
  assign enc_in          = di;
`endif

  // Encode and puncture: decide which of A/B enter the FIFO this cycle
  assign code_a = parity7(G0, {enc_in, sr});
  assign code_b = parity7(G1, {enc_in, sr});

  always_comb begin
    push_n    = 2'd2;
    b0        = code_a;
    b1        = code_b;
    phase_nxt = 2'd0;
    case (rate_q)
      RATE_23: begin
        if (phase == 2'd0) begin
          phase_nxt = 2'd1;
        end else begin
          push_n = 2'd1;
        end
      end
      RATE_34: begin
        if (phase == 2'd0) begin
          phase_nxt = 2'd1;
        end else if (phase == 2'd1) begin
          push_n    = 2'd1;
          phase_nxt = 2'd2;
        end else begin
          push_n = 2'd1;
          b0     = code_b;
        end
      end
      default: ;
    endcase
    if (!enc_step) begin
      push_n = 2'd0;
    end
  end

  // FIFO: head lives at mem[0], entries shift down on pop
  assign do_vld      = (cnt != '0);
  assign do_bit      = do_vld & mem[0];
  assign pop         = do_vld & do_rdy & ~start;
  assign wr_i        = int'(cnt) - (pop ? 1 : 0);
  assign cnt_nxt     = cnt + CNT_W'(push_n) - CNT_W'(pop);
  assign do_sym_last = do_vld & (bit_cnt == (n_cbps - CBPS_ONE));
  assign do_sym_num  = sym_num;

  always_ff @(posedge sce_clk_i) begin
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      if (pop) begin
        mem[i] <= mem[i+1];
      end
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((push_n != 2'd0) && (i == wr_i)) begin
        mem[i] <= b0;
      end
      if ((push_n == 2'd2) && (i == wr_i + 1)) begin
        mem[i] <= b1;
      end
    end
  end

  // Control state: encoder register, puncture phase, fill level, symbol counters
  always_ff @(posedge sce_clk_i or posedge sce_rst) begin
    if (sce_rst) begin
      sr      <= 6'd0;
      rate_q  <= RATE_12;
      phase   <= 2'd0;
      cnt     <= '0;
      rdy_en  <= 1'b0;
      bit_cnt <= '0;
      sym_num <= 4'd0;
    end else begin
      rdy_en <= 1'b1;
      if (start) begin
        sr      <= init_state;
        rate_q  <= (rate == 2'd3) ? RATE_12 : rate;
        phase   <= 2'd0;
        cnt     <= '0;
        bit_cnt <= '0;
        sym_num <= 4'd0;
      end else begin
        if (enc_step) begin
          sr    <= {enc_in, sr[5:1]};
          phase <= phase_nxt;
        end
        cnt <= cnt_nxt;
        if (pop) begin
          if (do_sym_last) begin
            bit_cnt <= '0;
            sym_num <= sym_num + 4'd1;
          end else begin
            bit_cnt <= bit_cnt + CBPS_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cenc_punc_enc.sv
// Directed self-checking bench for cenc_punc_enc: impulse response, puncturing, symbol tagging,
// backpressure, start priority, async reset and (with CENC_TAIL_EN) tail insertion.
`timescale 1ns/1ps

module tb_cenc_punc_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rate = 2'd0;
  logic [5:0] init_state = 6'd0;
  logic [8:0] n_cbps = 9'd100;
  logic       di = 1'b0;
  logic       di_vld = 1'b0;
  logic       di_rdy;
  logic       tail_req = 1'b0;
  logic       tail_busy;
  logic       do_bit;
  logic       do_vld;
  logic       do_rdy = 1'b1;
  logic       do_sym_last;
  logic [3:0] do_sym_num;

  int n_assert = 0;
  int n_fail   = 0;

  logic       cap_bit[$];
  logic       cap_last[$];
  logic [3:0] cap_num[$];

  cenc_punc_enc #(
    .G0(7'o133), .G1(7'o171), .FIFO_DEPTH(4), .CBPS_W(9)
  ) dut (
    .sce_clk_i(clk), .sce_rst(rst), .start(start), .rate(rate),
    .init_state(init_state), .n_cbps(n_cbps), .di(di), .di_vld(di_vld),
    .di_rdy(di_rdy), .tail_req(tail_req), .tail_busy(tail_busy),
    .do_bit(do_bit), .do_vld(do_vld), .do_rdy(do_rdy),
    .do_sym_last(do_sym_last), .do_sym_num(do_sym_num)
  );

  always #5 clk = ~clk;

  // Record every bit that will be popped at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && do_vld && do_rdy && !start) begin
      cap_bit.push_back(do_bit);
      cap_last.push_back(do_sym_last);
      cap_num.push_back(do_sym_num);
    end
  end

  function automatic logic [63:0] packed_cap();
    logic [63:0] w = '0;
    foreach (cap_bit[i]) w = {w[62:0], cap_bit[i]};
    return w;
  endfunction

  task automatic clear_cap();
    cap_bit.delete();
    cap_last.delete();
    cap_num.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    di = b;
    di_vld = 1'b1;
    @(negedge clk);
    while (!di_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_assert++; n_fail++;
      $display("FAIL send_bit_timeout: di_rdy=%0b required 1", di_rdy);
    end
    tick();
    di_vld = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] r, input logic [5:0] init);
    start = 1'b1;
    rate = r;
    init_state = init;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while (do_vld && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_assert++; n_fail++;
      $display("FAIL drain_timeout: do_vld=%0b required 0", do_vld);
    end
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_di_rdy: got %0b required 0", di_rdy); end
    n_assert++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL rst_do_vld: got %0b required 0", do_vld); end
    n_assert++; if (do_bit !== 1'b0) begin n_fail++; $display("FAIL rst_do: got %0b required 0", do_bit); end
    n_assert++; if (do_sym_last !== 1'b0) begin n_fail++; $display("FAIL rst_sym_last: got %0b required 0", do_sym_last); end
    n_assert++; if (do_sym_num !== 4'd0) begin n_fail++; $display("FAIL rst_sym_num: got %0d required 0", do_sym_num); end
    n_assert++; if (tail_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tail_busy: got %0b required 0", tail_busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_di_rdy_early: got %0b required 0", di_rdy); end
    tick();
    n_assert++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_di_rdy: got %0b required 1", di_rdy); end
  endtask

  task automatic test_impulse();
    do_start(2'd0, 6'd0);
    clear_cap();
    send_bit(1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    drain();
    n_assert++; if (cap_bit.size() !== 14) begin n_fail++; $display("FAIL impulse_len: got %0d required 14", cap_bit.size()); end
    n_assert++; if (packed_cap() !== 64'b11011111001011) begin n_fail++; $display("FAIL impulse_bits: got %0h required %0h", packed_cap(), 64'b11011111001011); end
  endtask

  task automatic test_puncture();
    logic in_v [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_start(2'd2, 6'd0);
    clear_cap();
    for (int i = 0; i < 6; i++) send_bit(in_v[i]);
    drain();
    n_assert++; if (cap_bit.size() !== 8) begin n_fail++; $display("FAIL r34_len: got %0d required 8", cap_bit.size()); end
    n_assert++; if (packed_cap() !== 64'b11000110) begin n_fail++; $display("FAIL r34_bits: got %0h required %0h", packed_cap(), 64'b11000110); end
    do_start(2'd1, 6'd0);
    clear_cap();
    for (int i = 0; i < 4; i++) send_bit(in_v[i]);
    drain();
    n_assert++; if (cap_bit.size() !== 6) begin n_fail++; $display("FAIL r23_len: got %0d required 6", cap_bit.size()); end
    n_assert++; if (packed_cap() !== 64'b110000) begin n_fail++; $display("FAIL r23_bits: got %0h required %0h", packed_cap(), 64'b110000); end
    do_start(2'd3, 6'd0);
    clear_cap();
    for (int i = 0; i < 6; i++) send_bit(in_v[i]);
    drain();
    n_assert++; if (cap_bit.size() !== 12) begin n_fail++; $display("FAIL r3_len: got %0d required 12", cap_bit.size()); end
    n_assert++; if (packed_cap() !== 64'b110100011010) begin n_fail++; $display("FAIL r3_bits: got %0h required %0h", packed_cap(), 64'b110100011010); end
  endtask

  task automatic test_symbol();
    int n_last = 0;
    n_cbps = 9'd48;
    do_start(2'd0, 6'd0);
    clear_cap();
    for (int i = 0; i < 48; i++) send_bit((i % 3) == 0);
    drain();
    foreach (cap_last[i]) if (cap_last[i]) n_last++;
    n_assert++; if (cap_bit.size() !== 96) begin n_fail++; $display("FAIL sym_len: got %0d required 96", cap_bit.size()); end
    n_assert++; if (n_last !== 2) begin n_fail++; $display("FAIL sym_last_count: got %0d required 2", n_last); end
    n_assert++; if (cap_last[47] !== 1'b1) begin n_fail++; $display("FAIL sym_last_48: got %0b required 1", cap_last[47]); end
    n_assert++; if (cap_last[95] !== 1'b1) begin n_fail++; $display("FAIL sym_last_96: got %0b required 1", cap_last[95]); end
    n_assert++; if (cap_num[0] !== 4'd0) begin n_fail++; $display("FAIL sym_num_first: got %0d required 0", cap_num[0]); end
    n_assert++; if (cap_num[48] !== 4'd1) begin n_fail++; $display("FAIL sym_num_second: got %0d required 1", cap_num[48]); end
    n_assert++; if (do_sym_num !== 4'd2) begin n_fail++; $display("FAIL sym_num_end: got %0d required 2", do_sym_num); end
    n_cbps = 9'd100;
  endtask

  task automatic test_backpressure();
    logic rdy_seen = 1'b0;
    do_start(2'd0, 6'd0);
    clear_cap();
    do_rdy = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_di_rdy_full: got %0b required 0", di_rdy); end
    n_assert++; if (do_vld !== 1'b1) begin n_fail++; $display("FAIL bp_do_vld: got %0b required 1", do_vld); end
    di = 1'b1;
    di_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (di_rdy) rdy_seen = 1'b1;
    end
    n_assert++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL bp_di_rdy_hold: got %0b required 0", rdy_seen); end
    tick();
    di_vld = 1'b0;
    do_rdy = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    drain();
    n_assert++; if (packed_cap() !== 64'b110100011010 || cap_bit.size() !== 12) begin
      n_fail++; $display("FAIL bp_stream: got %0h len %0d required %0h len 12", packed_cap(), cap_bit.size(), 64'b110100011010);
    end
  endtask

  task automatic test_start();
    do_start(2'd0, 6'd0);
    do_rdy = 1'b0;
    send_bit(1'b1);
    clear_cap();
    start = 1'b1;
    rate = 2'd0;
    init_state = 6'b111101;
    di = 1'b1;
    di_vld = 1'b1;
    @(negedge clk);
    n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL start_di_rdy: got %0b required 0", di_rdy); end
    tick();
    start = 1'b0;
    di_vld = 1'b0;
    @(negedge clk);
    n_assert++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL start_flush: got %0b required 0", do_vld); end
    tick();
    do_rdy = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    drain();
    n_assert++; if (cap_bit.size() !== 4) begin n_fail++; $display("FAIL start_len: got %0d required 4", cap_bit.size()); end
    n_assert++; if (packed_cap() !== 64'b1010) begin n_fail++; $display("FAIL start_sr_load: got %0h required %0h", packed_cap(), 64'b1010); end
  endtask

  task automatic test_async_reset();
    do_start(2'd0, 6'd0);
    do_rdy = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_assert++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL arst_do_vld: got %0b required 0", do_vld); end
    n_assert++; if (di_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_di_rdy: got %0b required 0", di_rdy); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_assert++; if (do_vld !== 1'b0) begin n_fail++; $display("FAIL arst_no_residue: got %0b required 0", do_vld); end
    tick();
    do_rdy = 1'b1;
    clear_cap();
    send_bit(1'b1);
    drain();
    n_assert++; if (packed_cap() !== 64'b11 || cap_bit.size() !== 2) begin
      n_fail++; $display("FAIL arst_fresh: got %0h len %0d required 3 len 2", packed_cap(), cap_bit.size());
    end
  endtask

`ifdef CENC_TAIL_EN
  task automatic test_tail();
    int busy_cnt = 0;
    int t = 0;
    logic rdy_seen = 1'b0;
    do_start(2'd0, 6'd0);
    clear_cap();
    for (int i = 0; i < 10; i++) send_bit(i == 4);
    tail_req = 1'b1;
    tick();
    tail_req = 1'b0;
    @(negedge clk);
    while (tail_busy && t < 100) begin
      busy_cnt++;
      if (di_rdy) rdy_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    n_assert++; if (busy_cnt < 6) begin n_fail++; $display("FAIL tail_busy_len: got %0d required >=6", busy_cnt); end
    n_assert++; if (tail_busy !== 1'b0) begin n_fail++; $display("FAIL tail_busy_end: got %0b required 0", tail_busy); end
    n_assert++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL tail_di_rdy: got %0b required 0", rdy_seen); end
    tick();
    send_bit(1'b0);
    send_bit(1'b0);
    drain();
    n_assert++; if (packed_cap() !== 64'h00DF2C000 || cap_bit.size() !== 36) begin
      n_fail++; $display("FAIL tail_stream: got %0h len %0d required 0df2c000 len 36", packed_cap(), cap_bit.size());
    end
  endtask
`else
  task automatic test_tail_disabled();
    do_start(2'd0, 6'd0);
    tail_req = 1'b1;
    tick();
    tail_req = 1'b0;
    @(negedge clk);
    n_assert++; if (tail_busy !== 1'b0) begin n_fail++; $display("FAIL notail_busy: got %0b required 0", tail_busy); end
    n_assert++; if (di_rdy !== 1'b1) begin n_fail++; $display("FAIL notail_di_rdy: got %0b required 1", di_rdy); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_impulse();
    test_puncture();
    test_symbol();
    test_backpressure();
    test_start();
    test_async_reset();
`ifdef CENC_TAIL_EN
    test_tail();
`else
    test_tail_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
